// File: rtl/riscv_muldiv_unit.sv
// ============================================================================
// Module   : riscv_muldiv_unit
// Brief    : RV32M execute unit. It has a 2-cycle multiply and an XLEN-step
//            restoring divider, with valid/ready handshakes on the request
//            and result sides.
//            Optional macro RISCV_MULDIV_RESULT_CACHE_EN stores the last
//            completed division so that a repeat of it finishes in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            func,
    input  logic [XLEN-1:0]       rs1_val,
    input  logic [XLEN-1:0]       rs2_val,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       result,
    output logic [REG_ADDR_W-1:0] rd_out
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DIV  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam int                  c_CNT_W = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(XLEN - 1);
    localparam logic [c_CNT_W-1:0]  c_ONE   = c_CNT_W'(1);
    localparam logic [XLEN-1:0]     c_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [XLEN-1:0]       r_a;
    logic [XLEN-1:0]       r_b;
    logic [XLEN-1:0]       r_quo;
    logic [XLEN-1:0]       r_rem;
    logic [XLEN-1:0]       r_result;
    logic [1:0]            r_op;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [c_CNT_W-1:0]    r_cnt;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_in_muldiv;
    logic            w_in_div;
    logic            w_in_signed;
    logic            w_in_zero;
    logic            w_in_ovf;
    logic            w_in_special;
    logic            w_hit;
    logic [XLEN-1:0] w_hit_res;
    logic [XLEN-1:0] w_acc_res;
    logic [XLEN-1:0] w_in_a_mag;
    logic [1:0]      w_acc_next;

    assign w_accept     = in_valid && (r_state == c_IDLE) && !flush;
    assign w_in_muldiv  = (func[4:3] == 2'b01);
    assign w_in_div     = w_in_muldiv && func[2];
    assign w_in_signed  = !func[0];
    assign w_in_zero    = (rs2_val == '0);
    assign w_in_ovf     = w_in_signed && (rs1_val == c_MIN) && (rs2_val == '1);
    assign w_in_special = w_in_div && (w_in_zero || w_in_ovf);
    assign w_in_a_mag   = (w_in_signed && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;

    always_comb begin
        w_acc_next = c_DONE;
        if (w_in_muldiv) begin
            if (!func[2]) begin
                w_acc_next = c_MUL;
            end else if (!w_in_special && !w_hit) begin
                w_acc_next = c_DIV;
            end
        end
    end

    // Anything that finishes at accept (invalid, special, cache hit) resolves here
    always_comb begin
        w_acc_res = '0;
        if (w_in_div) begin
            if (w_in_zero) begin
                w_acc_res = func[1] ? rs1_val : '1;
            end else if (w_in_ovf) begin
                w_acc_res = func[1] ? '0 : c_MIN;
            end else if (w_hit) begin
                w_acc_res = w_hit_res;
            end
        end
    end

    // ------------------------------------------------------------------
    // Multiply and divide-step datapath
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;
    logic              w_r_signed;
    logic              w_neg_q;
    logic              w_neg_r;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;
    logic [XLEN-1:0]   w_div_res;

    // Sign extension to 2*XLEN makes the low 2*XLEN product bits exact for all variants
    assign w_a_ext   = {{XLEN{(r_op != 2'b11) & r_a[XLEN-1]}}, r_a};
    assign w_b_ext   = {{XLEN{(r_op == 2'b01) & r_b[XLEN-1]}}, r_b};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_mul_res = (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    assign w_r_signed = !r_op[0];
    assign w_neg_q    = w_r_signed && (r_a[XLEN-1] ^ r_b[XLEN-1]);
    assign w_neg_r    = w_r_signed && r_a[XLEN-1];
    assign w_b_mag    = (w_r_signed && r_b[XLEN-1]) ? -r_b : r_b;

    assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, w_b_mag};
    assign w_ge      = !w_diff[XLEN];
    assign w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
    assign w_q_fix   = w_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_r_fix   = w_neg_r ? -w_rem_nxt : w_rem_nxt;
    assign w_div_res = r_op[1] ? w_r_fix : w_q_fix;

`ifdef RISCV_MULDIV_RESULT_CACHE_EN
    logic            r_c_valid;
    logic            r_c_signed;
    logic [XLEN-1:0] r_c_a;
    logic [XLEN-1:0] r_c_b;
    logic [XLEN-1:0] r_c_quo;
    logic [XLEN-1:0] r_c_rem;

    assign w_hit     = r_c_valid && w_in_div && !w_in_special &&
                       (rs1_val == r_c_a) && (rs2_val == r_c_b) &&
                       (w_in_signed == r_c_signed);
    assign w_hit_res = func[1] ? r_c_rem : r_c_quo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_valid  <= 1'b0;
            r_c_signed <= 1'b0;
            r_c_a      <= '0;
            r_c_b      <= '0;
            r_c_quo    <= '0;
            r_c_rem    <= '0;
        end else if (flush || (w_accept && w_in_special)) begin
            r_c_valid <= 1'b0;
        end else if ((r_state == c_DIV) && (r_cnt == c_LAST)) begin
            r_c_valid  <= 1'b1;
            r_c_signed <= w_r_signed;
            r_c_a      <= r_a;
            r_c_b      <= r_b;
            r_c_quo    <= w_q_fix;
            r_c_rem    <= w_r_fix;
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_a   <= rs1_val;
            r_b   <= rs2_val;
            r_op  <= func[1:0];
            r_rd  <= rd_in;
            r_cnt <= '0;
            r_quo <= w_in_a_mag;
            r_rem <= '0;
            if (w_acc_next == c_DONE) begin
                r_result <= w_acc_res;
            end
        end else if (r_state == c_MUL) begin
            r_result <= w_mul_res;
        end else if (r_state == c_DIV) begin
            r_cnt <= r_cnt + c_ONE;
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
            if (r_cnt == c_LAST) begin
                r_result <= w_div_res;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_nxt = w_acc_next;
            c_MUL:   w_state_nxt = c_DONE;
            c_DIV:   if (r_cnt == c_LAST) w_state_nxt = c_DONE;
            c_DONE:  if (out_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = c_IDLE;
        end
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
        result    = r_result;
        rd_out    = r_rd;
    end

endmodule

`default_nettype wire
